// File: rtl/i_bram_reader_pkg.sv
// Shared definitions for the I vector BRAM reader: default sizes, state
// encoding and the skid FIFO depth rule.
package i_bram_reader_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_RD_LAT = 2;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_w_t;

    typedef enum state_w_t {
        ST_IDLE    = 3'd0,
        ST_WAIT_WR = 3'd1,
        ST_READ    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Two spare entries beyond the read latency keep the stream gap-free at
    // full rate while the credit check lags one cycle behind pops.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/i_bram_reader_if.sv
// BRAM read port plus downstream valid/ready stream of the I vector reader.
interface i_bram_reader_if
    import i_bram_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output bram_en,
        output bram_addr,
        input  bram_dout,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  bram_en,
        input  bram_addr,
        output bram_dout,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/i_bram_reader_skid_fifo.sv
// First-word-fall-through skid FIFO catching BRAM read data; flush empties it
// in one cycle. A push and pop together on an empty FIFO shows data next cycle.
module i_rd_skid_fifo #(
    parameter  int DATA_W = 16,
    parameter  int FIFO_D = 4,
    localparam int CNT_W  = $clog2(FIFO_D + 1),
    localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [DATA_W-1:0] mem_q [FIFO_D];
    ptr_t              wr_q;
    ptr_t              rd_q;
    cnt_t              count_q;
    logic              pop_ok;
    logic              push_ok;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (int'(p) == FIFO_D - 1) ? '0 : p + ptr_t'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == cnt_t'(FIFO_D));
    assign count   = count_q;
    assign dout    = mem_q[rd_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values regardless of the order of statements or blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_q <= ptr_inc(wr_q);
            if (pop_ok)  rd_q <= ptr_inc(rd_q);
            count_q <= count_q + cnt_t'(push_ok) - cnt_t'(pop_ok);
        end
    end

    // NOTE: the storage array has no reset; count_q alone defines which
    // entries are meaningful, and leaving data flops unreset keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/i_bram_reader.sv
// Read-side controller for the I vector BRAM: waits for the writer, issues
// credit-limited sequential reads and streams the data downstream.
module i_bram_reader
    import i_bram_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int FIFO_D = fifo_depth(RD_LAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              i_done,
    i_bram_reader_if.master   bus,
    output logic              busy,
    output logic              rd_done
);

    localparam int CNT_W = $clog2(FIFO_D + 1);

    typedef logic [ADDR_W:0]  idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    state_e            state_q;
    idx_t              len_q;
    idx_t              issue_q;
    idx_t              issue_d;
    idx_t              out_cnt_q;
    idx_t              out_cnt_d;
    logic [RD_LAT-1:0] pipe_q;
    logic [RD_LAT-1:0] pipe_d;
    logic              busy_q;
    logic              rd_done_q;

    cnt_t              inflight;
    cnt_t              fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;
    logic              credit_ok;
    logic              bram_en;
    logic              last_issue;

    // NOTE: every signal driven in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + cnt_t'(pipe_q[i]);
    end

    // Credit uses the registered FIFO count: a same-cycle pop is not credited.
    assign credit_ok  = !fifo_full && ((int'(inflight) + int'(fifo_count)) < FIFO_D);
    assign bram_en    = (state_q == ST_READ) && !start && credit_ok;
    assign last_issue = bram_en && ((issue_q + idx_t'(1)) == len_q);
    assign issue_d    = issue_q + idx_t'(bram_en);

    assign fifo_push  = pipe_q[RD_LAT-1];
    assign fifo_pop   = !fifo_empty && bus.out_ready;
    assign out_cnt_d  = out_cnt_q + idx_t'(fifo_pop);

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = bram_en;
        for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            issue_q   <= '0;
            out_cnt_q <= '0;
            pipe_q    <= '0;
            busy_q    <= 1'b0;
            rd_done_q <= 1'b0;
        end else if (start) begin
            state_q   <= ST_WAIT_WR;
            len_q     <= len;
            issue_q   <= '0;
            out_cnt_q <= '0;
            pipe_q    <= '0;
            busy_q    <= 1'b1;
            rd_done_q <= 1'b0;
        end else begin
            issue_q   <= issue_d;
            out_cnt_q <= out_cnt_d;
            pipe_q    <= pipe_d;
            unique case (state_q)
                ST_WAIT_WR: begin
                    if (len_q == '0) begin
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        rd_done_q <= 1'b1;
                    end else if (i_done) begin
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (last_issue) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Only len reads were issued, so the len-th transfer
                    // leaves both the pipe and the FIFO empty.
                    if (out_cnt_d == len_q) begin
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        rd_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    i_rd_skid_fifo #(
        .DATA_W (DATA_W),
        .FIFO_D (FIFO_D)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.bram_dout),
        .dout  (bus.out_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign bus.bram_en   = bram_en;
    assign bus.bram_addr = issue_q[ADDR_W-1:0];
    assign bus.out_valid = !fifo_empty;
    assign busy          = busy_q;
    assign rd_done       = rd_done_q;

endmodule

// File: tb/tb_i_bram_reader.sv
// Scoreboard bench for i_bram_reader: stimulus queues expected words, a
// negedge monitor pops and compares them on every accepted transfer.
module tb_i_bram_reader;
    import i_bram_reader_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              i_done;
    logic              busy;
    logic              rd_done;

    i_bram_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    i_bram_reader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .i_done  (i_done),
        .bus     (bus),
        .busy    (busy),
        .rd_done (rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model with two-cycle latency, BRAM[k] = k + 100
    logic [ADDR_W-1:0] bram_a1;
    always @(posedge clk) begin
        bram_a1       <= bus.bram_addr;
        bus.bram_dout <= DATA_W'(bram_a1) + DATA_W'(100);
    end

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;
    int xfers = 0;
    int first_xfer_cyc = 0;
    int last_xfer_cyc = 0;
    int done_cyc = 0;
    int max_cred = 0;
    bit overflow_seen = 1'b0;
    bit en_low_seen = 1'b0;
    bit en_seen = 1'b0;
    bit valid_seen = 1'b0;
    logic [31:0] exp_q[$];

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare plus credit / overflow observation
    always @(negedge clk) begin
        logic [31:0] exp_v;
        int cred;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_xfer: got data %0d, expected no transfer", bus.out_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("out_data", 32'(bus.out_data), exp_v);
                end
                if (xfers == 0) first_xfer_cyc = cycle;
                last_xfer_cyc = cycle;
                xfers++;
            end
            cred = int'(dut.inflight) + int'(dut.fifo_count);
            if (cred > max_cred) max_cred = cred;
            if (dut.fifo_push && dut.fifo_full && !dut.fifo_pop) overflow_seen = 1'b1;
            if (dut.state_q == ST_READ && !bus.bram_en) en_low_seen = 1'b1;
            if (bus.bram_en) en_seen = 1'b1;
            if (bus.out_valid) valid_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        exp_q.delete();
        for (int k = 0; k < l; k++) exp_q.push_back(32'(100 + k));
        xfers = 0;
        start = 1'b1;
        len   = (ADDR_W+1)'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        done_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            if (rd_done) break;
            tick();
        end
        if (rd_done) done_cyc = cycle;
        check(name, 32'(rd_done), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bram_en"},   32'(bus.bram_en),   32'd0);
        check({tag, "_bram_addr"}, 32'(bus.bram_addr), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),          32'd0);
        check({tag, "_rd_done"},   32'(rd_done),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        len = '0;
        i_done = 1'b1;
        bus.out_ready = 1'b1;
        #2 rst = 1'b1;
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // 1: basic run, writer already done
        do_start(8);
        check("t1_busy_wait", 32'(busy), 32'd1);
        tick();
        for (int k = 0; k < 8; k++) begin
            check("t1_en_addr", {22'd0, bus.bram_en, bus.bram_addr}, {22'd0, 1'b1, 9'(k)});
            tick();
        end
        wait_done("t1_done", 40);
        check("t1_xfers", 32'(xfers), 32'd8);
        check("t1_no_gaps", 32'(last_xfer_cyc - first_xfer_cyc), 32'd7);
        check("t1_done_lat", 32'(done_cyc - last_xfer_cyc), 32'd1);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: wait for writer
        i_done = 1'b0;
        do_start(4);
        for (int k = 0; k < 10; k++) begin
            check("t2_wait_en_busy", {30'd0, bus.bram_en, busy}, 32'd1);
            tick();
        end
        i_done = 1'b1;
        check("t2_en_same_cycle", 32'(bus.bram_en), 32'd0);
        tick();
        check("t2_en_next_cycle", {22'd0, bus.bram_en, bus.bram_addr}, {22'd0, 1'b1, 9'd0});
        wait_done("t2_done", 40);
        check("t2_xfers", 32'(xfers), 32'd4);

        // 3: backpressure 1,0,0,1
        max_cred = 0;
        en_low_seen = 1'b0;
        do_start(16);
        for (int i = 0; i < 300; i++) begin
            if (rd_done) break;
            bus.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            tick();
        end
        bus.out_ready = 1'b1;
        check("t3_done", 32'(rd_done), 32'd1);
        check("t3_xfers", 32'(xfers), 32'd16);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t3_credit_le_4", 32'(max_cred <= 4), 32'd1);
        check("t3_en_throttled", 32'(en_low_seen), 32'd1);

        // 4: zero length
        en_seen = 1'b0;
        valid_seen = 1'b0;
        do_start(0);
        tick();
        check("t4_done_2cyc", 32'(rd_done), 32'd1);
        repeat (3) tick();
        check("t4_no_en", 32'(en_seen), 32'd0);
        check("t4_no_valid", 32'(valid_seen), 32'd0);

        // 5: restart mid-stream
        do_start(16);
        for (int i = 0; i < 60; i++) begin
            if (xfers >= 5) break;
            tick();
        end
        check("t5_reached_5", 32'(xfers), 32'd5);
        bus.out_ready = 1'b0;
        do_start(3);
        check("t5_flushed", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        wait_done("t5_done", 40);
        check("t5_xfers", 32'(xfers), 32'd3);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: asynchronous reset mid-READ
        do_start(16);
        repeat (3) tick();
        check("t6_in_read", 32'(bus.bram_en), 32'd1);
        #2;
        exp_q.delete();
        rst = 1'b1;
        #1;
        check_outputs_zero("t6_async");
        tick();
        rst = 1'b0;
        tick();
        do_start(2);
        wait_done("t6_done", 40);
        check("t6_xfers", 32'(xfers), 32'd2);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        check("fifo_no_overflow", 32'(overflow_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/i_bram_reader.md
Name: i_bram_reader

Overview:
- Read-side controller for the I vector BRAM. The write side (sigmoid output path) fills this BRAM and then raises its done flag.
- This block waits for that flag, then issues sequential BRAM reads, compensates for the fixed BRAM read latency, and streams the entries to the downstream element-wise stage over a valid/ready interface.
- A credit-limited skid FIFO ensures that no read data is lost under backpressure.

Parameters:
- DATA_W, 16, width of one I vector element.
- ADDR_W, 9, BRAM address width.
- RD_LAT, 2, BRAM read latency in cycles, from en/addr to dout valid. Legal range 1..4.
- FIFO_D, RD_LAT+2, skid FIFO depth in entries.

Ports:
- clk  in  1  the block's only clock; everything is on its rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- start  in  1  single-cycle pulse; latches len and (re)arms the reader.
- len  in  ADDR_W+1  number of elements to read; sampled only when start=1.
- i_done  in  1  level from the I write controller: the BRAM contents are complete.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_W  BRAM read address.
- bram_dout  in  DATA_W  BRAM read data, valid RD_LAT cycles after bram_en.
- out_data  out  DATA_W  streamed element (FIFO head).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- busy  out  1  high in WAIT_WR, READ and DRAIN.
- rd_done  out  1  level; set when all len elements have been transferred, cleared by start or rst.

Behaviour:
- Reset values: bram_en=0, bram_addr=0, out_valid=0, busy=0, rd_done=0. Also state=IDLE, all counters 0, FIFO empty, latency pipe cleared.
- States:
  - IDLE: waits for start.
  - WAIT_WR: entered on start. Moves to READ when i_done=1. If len=0 it goes directly to DONE instead.
  - READ: issues reads. Moves to DRAIN in the same cycle the len-th read is issued.
  - DRAIN: waits until the pipe is empty and the FIFO is empty, then moves to DONE.
  - DONE: holds rd_done=1 until start.
- start has priority in every state, including mid-READ and mid-DRAIN. It:
  - flushes the FIFO;
  - marks in-flight pipe entries invalid, so returning data is discarded;
  - clears both counters and rd_done;
  - goes to WAIT_WR.
- Read issue: bram_en=1 in a READ cycle only when inflight + fifo_count < FIFO_D.
  - inflight is the number of valid bits in the RD_LAT-stage pipe.
  - fifo_count uses its registered value, so a pop in the same cycle is not credited until the next cycle.
- Addressing: bram_addr equals the issue counter, starting at 0 and incrementing on each issued read. bram_addr holds its value when bram_en=0.
- Valid pipe: shift register of RD_LAT bits, bit0 = bram_en. When the last stage is 1, bram_dout is pushed into the FIFO that cycle.
- Credit rule: the FIFO never overflows. An overflow attempt is a design error; the bench asserts on it.
- Output: out_valid = FIFO non-empty, and out_data = FIFO head (first-word-fall-through). The FIFO pops on out_valid && out_ready.
  - Simultaneous push and pop on a full FIFO is legal.
  - Simultaneous push and pop on an empty FIFO passes the data through on the next cycle, not combinationally.
- Counters: out_cnt increments on each transfer. Entering DONE requires out_cnt == len.
- Steady-state throughput is 1 element/cycle with out_ready held at 1. First-data latency is RD_LAT+1 cycles after READ is entered.
- If i_done drops during READ, it is ignored. It is sampled only in WAIT_WR.
- Maximum len is 2^ADDR_W. The address never wraps within one run.

Decomposition:
- Shared package: state encoding constants (IDLE, WAIT_WR, READ, DRAIN, DONE), default DATA_W/ADDR_W/RD_LAT values, and a type for the state register width.
- One sub-module, i_rd_skid_fifo: synchronous FWFT FIFO with parameters DATA_W and FIFO_D. Ports: push, pop, din, dout, empty, full, count, flush. Asynchronous active-high reset.

Test Plan:
1. Basic run, i_done already high: rst pulse, then start with len=8, out_ready=1, BRAM[k]=k+100, RD_LAT=2.
   - bram_addr runs 0..7 on consecutive cycles.
   - out_data = 100..107 with no gaps.
   - rd_done rises one cycle after the 8th transfer; busy is 0 afterwards.
2. Wait for writer: start with len=4 and i_done=0 for 10 cycles.
   - bram_en stays 0 and busy=1 throughout.
   - When i_done rises, reads begin on the next cycle and 4 correct elements are streamed.
3. Backpressure: len=16, out_ready toggling 1,0,0,1 repeatedly.
   - All 16 values arrive in order with no duplicates.
   - inflight + fifo_count never exceeds 4.
   - bram_en deasserts while credit is exhausted.
4. Zero length: start with len=0 and i_done=1.
   - bram_en is never asserted and out_valid stays 0.
   - rd_done=1 within 2 cycles.
5. Restart mid-stream: len=16, then start again with len=3 after 5 transfers.
   - FIFO is flushed and in-flight data discarded.
   - Exactly 3 elements 100..102 follow, then rd_done.
6. Asynchronous reset mid-READ: assert rst between clock edges.
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After release, a new start with len=2 streams 100,101 correctly.
